aes_inv_cipher_iter: RTL and testbench

Iterative AES inverse cipher. It accepts one 128-bit ciphertext block and computes one inverse round per clock. Each round applies InvShiftRows, InvSubBytes, AddRoundKey and InvMixColumns. Round keys come from an external key store, indexed by rk_idx. The block sits on the decrypt path, mirroring the encrypt-side round datapath (shift_rows / sub_bytes / mix_columns).

---
 rtl/aes_inv_cipher_iter_pkg.sv | 62 ++++++
 rtl/aes_inv_cipher_iter_if.sv | 25 ++
 rtl/aes_inv_cipher_iter_inv_sbox.sv | 28 ++
 rtl/aes_inv_cipher_iter.sv | 137 +++++++++++++
 tb/tb_aes_inv_cipher_iter.sv | 347 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/aes_inv_cipher_iter_pkg.sv
// Shared AES helpers: block/byte mapping and GF(2^8) arithmetic for the inverse round.
package aes_inv_cipher_iter_pkg;

    localparam int unsigned NB       = 4;
    localparam int unsigned BYTES    = 4 * NB;
    localparam int unsigned BLK_W    = 8 * BYTES;
    localparam int unsigned COL_W    = 32;
    localparam int unsigned RK_IDX_W = 4;

    // Element [15] holds s(0,0), element [0] holds s(3,3).
    typedef logic [BYTES-1:0][7:0] blk_bytes_t;

    // Packed element index of state byte s(r,c) in column-major order.
    function automatic int unsigned byte_idx(input int unsigned r, input int unsigned c);
        return BYTES - 1 - (r + NB * c);
    endfunction

    // LSB position of column c inside a 128-bit block.
    function automatic int unsigned col_lsb(input int unsigned c);
        return BLK_W - COL_W * (c + 1);
    endfunction

    function automatic blk_bytes_t block_to_bytes(input logic [BLK_W-1:0] blk);
        return blk_bytes_t'(blk);
    endfunction

    function automatic logic [BLK_W-1:0] bytes_to_block(input blk_bytes_t b);
        return BLK_W'(b);
    endfunction

    // Multiply by x modulo 0x11b.
    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    // Shift-and-add GF(2^8) multiply; the constant operand folds away in synthesis.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] k);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (k[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // InvMixColumns on one column; bits [31:24] are row 0.
    function automatic logic [COL_W-1:0] inv_mix_column(input logic [COL_W-1:0] col);
        logic [7:0] s0, s1, s2, s3;
        s0 = col[31:24];
        s1 = col[23:16];
        s2 = col[15:8];
        s3 = col[7:0];
        return {gmul(s0, 8'h0e) ^ gmul(s1, 8'h0b) ^ gmul(s2, 8'h0d) ^ gmul(s3, 8'h09),
                gmul(s0, 8'h09) ^ gmul(s1, 8'h0e) ^ gmul(s2, 8'h0b) ^ gmul(s3, 8'h0d),
                gmul(s0, 8'h0d) ^ gmul(s1, 8'h09) ^ gmul(s2, 8'h0e) ^ gmul(s3, 8'h0b),
                gmul(s0, 8'h0b) ^ gmul(s1, 8'h0d) ^ gmul(s2, 8'h09) ^ gmul(s3, 8'h0e)};
    endfunction

endpackage

// File: rtl/aes_inv_cipher_iter_if.sv
// Ciphertext-in / plaintext-out handshake plus the round-key lookup port.
interface aes_inv_cipher_iter_if;
    import aes_inv_cipher_iter_pkg::*;

    logic                in_valid;
    logic                in_ready;
    logic [BLK_W-1:0]    ct;
    logic [RK_IDX_W-1:0] rk_idx;
    logic [BLK_W-1:0]    rk;
    logic                out_valid;
    logic                out_ready;
    logic [BLK_W-1:0]    pt;
    logic                busy;

    modport master (
        output in_valid, ct, rk, out_ready,
        input  in_ready, rk_idx, out_valid, pt, busy
    );

    modport slave (
        input  in_valid, ct, rk, out_ready,
        output in_ready, rk_idx, out_valid, pt, busy
    );

endinterface

// File: rtl/aes_inv_cipher_iter_inv_sbox.sv
// AES inverse S-box as a 256-entry combinational lookup.
module aes_inv_cipher_iter_inv_sbox (
    input  logic [7:0] in_i,
    output logic [7:0] out_c_o
);

    localparam logic [0:255][7:0] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

    assign out_c_o = INV_SBOX[in_i];

endmodule

// File: rtl/aes_inv_cipher_iter.sv
// Iterative AES inverse cipher: one inverse round per clock, round keys fetched by index.
module aes_inv_cipher_iter
    import aes_inv_cipher_iter_pkg::*;
#(
    parameter int unsigned NR = 10
) (
    input logic                  clk,
    input logic                  rst_n,
    aes_inv_cipher_iter_if.slave cif
);

    if (!(NR == 10 || NR == 12 || NR == 14)) begin : g_nr_check
        $error("aes_inv_cipher_iter: NR must be 10, 12 or 14");
    end

    localparam int unsigned CNT_W = RK_IDX_W;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(NR);
    localparam logic [CNT_W-1:0] CNT_FIRST = CNT_W'(NR - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ROUND = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [BLK_W-1:0] st_q, st_d;
    logic [BLK_W-1:0] pt_q, pt_d;
    logic             out_valid_q, out_valid_d;
    logic             in_ready_q, in_ready_d;
    logic             busy_q, busy_d;
    logic [CNT_W-1:0] rk_idx_q, rk_idx_d;

    blk_bytes_t       st_bytes;
    blk_bytes_t       isr_bytes;
    blk_bytes_t       isb_bytes;
    logic [BLK_W-1:0] ark_blk;
    logic [BLK_W-1:0] imc_blk;

    assign st_bytes = block_to_bytes(st_q);

    // InvShiftRows: row r rotates right by r bytes (pure wiring).
    for (genvar c = 0; c < NB; c++) begin : g_col
        for (genvar r = 0; r < NB; r++) begin : g_row
            assign isr_bytes[byte_idx(r, c)] = st_bytes[byte_idx(r, (c + NB - r) % NB)];
        end
    end

    // InvSubBytes on all sixteen bytes.
    for (genvar i = 0; i < BYTES; i++) begin : g_sbox
        aes_inv_cipher_iter_inv_sbox u_inv_sbox (
            .in_i    (isr_bytes[i]),
            .out_c_o (isb_bytes[i])
        );
    end

    // AddRoundKey; this is also the plaintext of the last round.
    assign ark_blk = bytes_to_block(isb_bytes) ^ cif.rk;

    // InvMixColumns column by column for the full rounds.
    always_comb begin
        imc_blk = '0;
        for (int unsigned c = 0; c < NB; c++) begin
            imc_blk[col_lsb(c) +: COL_W] = inv_mix_column(ark_blk[col_lsb(c) +: COL_W]);
        end
    end

    // Next-state, datapath and output decode.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        st_d        = st_q;
        pt_d        = pt_q;
        out_valid_d = out_valid_q;
        case (state_q)
            S_IDLE: begin
                if (cif.in_valid) begin
                    st_d    = cif.ct ^ cif.rk;
                    cnt_d   = CNT_FIRST;
                    state_d = S_ROUND;
                end
            end
            S_ROUND: begin
                if (cnt_q == '0) begin
                    pt_d        = ark_blk;
                    out_valid_d = 1'b1;
                    cnt_d       = CNT_LAST;
                    state_d     = S_DONE;
                end else begin
                    st_d  = imc_blk;
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_DONE: begin
                if (out_valid_q && cif.out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        in_ready_d = (state_d == S_IDLE);
        busy_d     = (state_d != S_IDLE);
        rk_idx_d   = (state_d == S_ROUND) ? cnt_d : CNT_LAST;
    end

    // State and output registers; reset abandons any block in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= CNT_LAST;
            st_q        <= '0;
            pt_q        <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            rk_idx_q    <= CNT_LAST;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            st_q        <= st_d;
            pt_q        <= pt_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
            busy_q      <= busy_d;
            rk_idx_q    <= rk_idx_d;
        end
    end

    assign cif.in_ready  = in_ready_q;
    assign cif.rk_idx    = rk_idx_q;
    assign cif.out_valid = out_valid_q;
    assign cif.pt        = pt_q;
    assign cif.busy      = busy_q;

endmodule

// File: tb/tb_aes_inv_cipher_iter.sv
// Directed and randomised checks of the iterative AES inverse cipher (NR=10 and NR=14).
module tb_aes_inv_cipher_iter;

    localparam logic [127:0] C1_CT   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] C3_CT   = 128'h8ea2b7ca516745bfeafc49904b496089;
    localparam logic [127:0] FIPS_PT = 128'h00112233445566778899aabbccddeeff;
    localparam logic [255:0] KEY128  = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
    localparam logic [255:0] KEY256  = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

    logic clk = 1'b0;
    logic rst_n;

    int n_checks;
    int n_fail;

    logic [127:0] rk10_cur [0:15];
    logic [127:0] rk14_cur [0:15];
    logic [127:0] ks [0:15];
    logic [7:0]   fsb [0:255];

    aes_inv_cipher_iter_if ifc10 ();
    aes_inv_cipher_iter_if ifc14 ();

    aes_inv_cipher_iter #(.NR(10)) dut10 (.clk(clk), .rst_n(rst_n), .cif(ifc10.slave));
    aes_inv_cipher_iter #(.NR(14)) dut14 (.clk(clk), .rst_n(rst_n), .cif(ifc14.slave));

    assign ifc10.rk = rk10_cur[ifc10.rk_idx];
    assign ifc14.rk = rk14_cur[ifc14.rk_idx];

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Forward S-box from the field inverse followed by the affine map.
    task automatic build_sbox();
        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv;
            inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (gf_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            fsb[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                         ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
        end
    endtask

    function automatic logic [7:0] get_b(input logic [127:0] b, input int r, input int c);
        return b[127 - 8 * (r + 4 * c) -: 8];
    endfunction

    function automatic logic [127:0] sub_bytes(input logic [127:0] b);
        logic [127:0] o;
        for (int i = 0; i < 16; i++) o[8 * i +: 8] = fsb[b[8 * i +: 8]];
        return o;
    endfunction

    function automatic logic [127:0] shift_rows(input logic [127:0] b);
        logic [127:0] o;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127 - 8 * (r + 4 * c) -: 8] = get_b(b, r, (c + r) % 4);
        return o;
    endfunction

    function automatic logic [127:0] mix_cols(input logic [127:0] b);
        logic [127:0] o;
        logic [7:0] s0, s1, s2, s3;
        for (int c = 0; c < 4; c++) begin
            s0 = get_b(b, 0, c);
            s1 = get_b(b, 1, c);
            s2 = get_b(b, 2, c);
            s3 = get_b(b, 3, c);
            o[127 - 32 * c -: 32] = {gf_mul(s0, 2) ^ gf_mul(s1, 3) ^ s2 ^ s3,
                                     s0 ^ gf_mul(s1, 2) ^ gf_mul(s2, 3) ^ s3,
                                     s0 ^ s1 ^ gf_mul(s2, 2) ^ gf_mul(s3, 3),
                                     gf_mul(s0, 3) ^ s1 ^ s2 ^ gf_mul(s3, 2)};
        end
        return o;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {fsb[w[31:24]], fsb[w[23:16]], fsb[w[15:8]], fsb[w[7:0]]};
    endfunction

    // Standard key schedule into ks[0..nr]; the key occupies the top 32*nk bits.
    task automatic key_expand(input logic [255:0] key, input int nk);
        logic [31:0] w [0:63];
        logic [31:0] t;
        logic [7:0]  rc;
        int nr;
        nr = nk + 6;
        rc = 8'h01;
        for (int i = 0; i < 64; i++) w[i] = '0;
        for (int i = 0; i < nk; i++) w[i] = key[255 - 32 * i -: 32];
        for (int i = nk; i < 4 * (nr + 1); i++) begin
            t = w[i - 1];
            if (i % nk == 0) begin
                t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = gf_mul(rc, 8'h02);
            end else if (nk > 6 && i % nk == 4) begin
                t = sub_word(t);
            end
            w[i] = w[i - nk] ^ t;
        end
        for (int r = 0; r < 16; r++)
            ks[r] = (r <= nr) ? {w[4 * r], w[4 * r + 1], w[4 * r + 2], w[4 * r + 3]} : '0;
    endtask

    function automatic logic [127:0] enc_block(input logic [127:0] p, input int nr);
        logic [127:0] s;
        s = p ^ ks[0];
        for (int rnd = 1; rnd <= nr; rnd++) begin
            s = shift_rows(sub_bytes(s));
            if (rnd != nr) s = mix_cols(s);
            s = s ^ ks[rnd];
        end
        return s;
    endfunction

    task automatic load_rk10();
        for (int i = 0; i < 16; i++) rk10_cur[i] = ks[i];
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog: time limit reached before end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        int wait_cnt;
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        ifc10.in_valid = 1'b0; ifc10.ct = '0; ifc10.out_ready = 1'b0;
        ifc14.in_valid = 1'b0; ifc14.ct = '0; ifc14.out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            rk10_cur[i] = '0;
            rk14_cur[i] = '0;
        end
        build_sbox();
        key_expand(KEY256, 8);
        for (int i = 0; i < 16; i++) rk14_cur[i] = ks[i];
        key_expand(KEY128, 4);
        load_rk10();
        repeat (2) tick();

        // Reset values
        check_eq("rst_in_ready", 128'(ifc10.in_ready), 128'd1);
        check_eq("rst_out_valid", 128'(ifc10.out_valid), 128'd0);
        check_eq("rst_pt", ifc10.pt, 128'd0);
        check_eq("rst_busy", 128'(ifc10.busy), 128'd0);
        check_eq("rst_rk_idx10", 128'(ifc10.rk_idx), 128'd10);
        check_eq("rst_rk_idx14", 128'(ifc14.rk_idx), 128'd14);
        rst_n = 1'b1;
        tick();

        // FIPS-197 C.1 with key index sequence and exact latency
        ifc10.out_ready = 1'b1;
        ifc10.ct = C1_CT;
        ifc10.in_valid = 1'b1;
        check_eq("t1_in_ready", 128'(ifc10.in_ready), 128'd1);
        for (int k = 0; k <= 10; k++) begin
            check_eq($sformatf("t1_rk_idx_T+%0d", k), 128'(ifc10.rk_idx), 128'(10 - k));
            check_eq($sformatf("t1_no_out_T+%0d", k), 128'(ifc10.out_valid), 128'd0);
            if (k == 1) check_eq("t1_busy", 128'(ifc10.busy), 128'd1);
            tick();
            ifc10.in_valid = 1'b0;
        end
        check_eq("t1_out_valid_T+11", 128'(ifc10.out_valid), 128'd1);
        check_eq("t1_pt", ifc10.pt, FIPS_PT);
        tick();
        check_eq("t1_idle_in_ready", 128'(ifc10.in_ready), 128'd1);
        check_eq("t1_idle_out_valid", 128'(ifc10.out_valid), 128'd0);
        check_eq("t1_idle_busy", 128'(ifc10.busy), 128'd0);

        // Backpressure: hold plaintext for 20 cycles, ignore a stray in_valid
        ifc10.out_ready = 1'b0;
        ifc10.ct = C1_CT;
        ifc10.in_valid = 1'b1;
        tick();
        ifc10.in_valid = 1'b0;
        wait_cnt = 0;
        while (!ifc10.out_valid && wait_cnt < 40) begin
            tick();
            wait_cnt++;
        end
        check_eq("t2_out_valid_rise", 128'(ifc10.out_valid), 128'd1);
        for (int k = 0; k < 20; k++) begin
            check_eq($sformatf("t2_hold_ov_%0d", k), 128'(ifc10.out_valid), 128'd1);
            check_eq($sformatf("t2_hold_pt_%0d", k), ifc10.pt, FIPS_PT);
            check_eq($sformatf("t2_hold_in_ready_%0d", k), 128'(ifc10.in_ready), 128'd0);
            if (k == 5) begin
                ifc10.in_valid = 1'b1;
                ifc10.ct = '0;
            end else begin
                ifc10.in_valid = 1'b0;
            end
            tick();
        end
        ifc10.in_valid = 1'b0;
        ifc10.out_ready = 1'b1;
        tick();
        check_eq("t2_release_in_ready", 128'(ifc10.in_ready), 128'd1);
        check_eq("t2_release_out_valid", 128'(ifc10.out_valid), 128'd0);
        check_eq("t2_release_busy", 128'(ifc10.busy), 128'd0);

        // Back-to-back with in_valid held high
        ifc10.ct = C1_CT;
        ifc10.in_valid = 1'b1;
        check_eq("t3_accept1", 128'(ifc10.in_ready), 128'd1);
        tick();
        ifc10.ct = '0;
        repeat (10) tick();
        check_eq("t3_pt1_valid", 128'(ifc10.out_valid), 128'd1);
        check_eq("t3_pt1", ifc10.pt, FIPS_PT);
        check_eq("t3_not_ready_T+11", 128'(ifc10.in_ready), 128'd0);
        key_expand(256'h0, 4);
        load_rk10();
        tick();
        check_eq("t3_ready_T+12", 128'(ifc10.in_ready), 128'd1);
        check_eq("t3_rk_idx_T+12", 128'(ifc10.rk_idx), 128'd10);
        tick();
        ifc10.in_valid = 1'b0;
        check_eq("t3_busy_T+13", 128'(ifc10.busy), 128'd1);
        check_eq("t3_rk_idx_T+13", 128'(ifc10.rk_idx), 128'd9);
        repeat (10) tick();
        check_eq("t3_pt2_valid", 128'(ifc10.out_valid), 128'd1);
        check_eq("t3_pt2_reencrypts_to_zero", enc_block(ifc10.pt, 10), 128'd0);
        tick();

        // Reset in the middle of a block and while holding a result
        key_expand(KEY128, 4);
        load_rk10();
        ifc10.ct = C1_CT;
        ifc10.in_valid = 1'b1;
        tick();
        ifc10.in_valid = 1'b0;
        repeat (4) tick();
        check_eq("t4_busy_before", 128'(ifc10.busy), 128'd1);
        rst_n = 1'b0;
        #1;
        check_eq("t4_abort_out_valid", 128'(ifc10.out_valid), 128'd0);
        check_eq("t4_abort_pt", ifc10.pt, 128'd0);
        check_eq("t4_abort_busy", 128'(ifc10.busy), 128'd0);
        tick();
        rst_n = 1'b1;
        check_eq("t4_in_ready_after", 128'(ifc10.in_ready), 128'd1);
        tick();
        check_eq("t4_no_resume", 128'(ifc10.busy), 128'd0);
        ifc10.ct = C1_CT;
        ifc10.in_valid = 1'b1;
        tick();
        ifc10.in_valid = 1'b0;
        repeat (10) tick();
        check_eq("t4_next_valid", 128'(ifc10.out_valid), 128'd1);
        check_eq("t4_next_pt", ifc10.pt, FIPS_PT);
        ifc10.out_ready = 1'b0;
        tick();
        ifc10.ct = C1_CT;
        ifc10.in_valid = 1'b1;
        tick();
        ifc10.in_valid = 1'b0;
        repeat (10) tick();
        check_eq("t4_done_valid", 128'(ifc10.out_valid), 128'd1);
        rst_n = 1'b0;
        #1;
        check_eq("t4_done_abort_ov", 128'(ifc10.out_valid), 128'd0);
        check_eq("t4_done_abort_pt", ifc10.pt, 128'd0);
        tick();
        rst_n = 1'b1;
        ifc10.out_ready = 1'b1;
        tick();
        check_eq("t4_done_in_ready", 128'(ifc10.in_ready), 128'd1);

        // FIPS-197 C.3 on the NR=14 instance
        ifc14.ct = C3_CT;
        ifc14.in_valid = 1'b1;
        for (int k = 0; k <= 14; k++) begin
            check_eq($sformatf("t5_rk_idx_T+%0d", k), 128'(ifc14.rk_idx), 128'(14 - k));
            tick();
            ifc14.in_valid = 1'b0;
        end
        check_eq("t5_out_valid_T+15", 128'(ifc14.out_valid), 128'd1);
        check_eq("t5_pt", ifc14.pt, FIPS_PT);
        tick();
        check_eq("t5_release", 128'(ifc14.out_valid), 128'd0);

        // Random keys and plaintexts with random gaps and backpressure
        ifc10.out_ready = 1'b0;
        for (int n = 0; n < 1000; n++) begin
            logic [127:0] key;
            logic [127:0] ptx;
            logic [127:0] ctx;
            bit got;
            key = {$urandom, $urandom, $urandom, $urandom};
            ptx = {$urandom, $urandom, $urandom, $urandom};
            key_expand({key, 128'h0}, 4);
            load_rk10();
            ctx = enc_block(ptx, 10);
            repeat ($urandom_range(0, 3)) tick();
            ifc10.ct = ctx;
            ifc10.in_valid = 1'b1;
            tick();
            ifc10.in_valid = 1'b0;
            ifc10.ct = {$urandom, $urandom, $urandom, $urandom};
            got = 1'b0;
            for (int w = 0; w < 60 && !got; w++) begin
                ifc10.out_ready = 1'($urandom_range(0, 1));
                if (ifc10.out_valid && ifc10.out_ready) begin
                    check_eq($sformatf("t6_pt_%0d", n), ifc10.pt, ptx);
                    got = 1'b1;
                end
                tick();
            end
            check_eq($sformatf("t6_delivered_%0d", n), 128'(got), 128'd1);
            check_eq($sformatf("t6_no_dup_%0d", n), 128'(ifc10.out_valid), 128'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
